// File: rtl/sensor_pkg.sv
// -----------------------------------------------------------------------------
// sensor_pkg
// Shared definitions for the street-B sensor conditioner:
//   - state_t     : FSM state encoding (IDLE, ARMING, REQ, SERVED)
//   - DEF_DEBOUNCE_CYCLES / DEF_CNT_W : default parameter values
//   - DB_W        : width of the debounce counter (covers 1..255)
// -----------------------------------------------------------------------------
package sensor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        REQ    = 2'd2,
        SERVED = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_W           = 8;
    localparam int DB_W                = 8;

endpackage : sensor_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output, lags d by two rising edges
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync_2ff

// File: rtl/sensor_conditioner.sv
// -----------------------------------------------------------------------------
// sensor_conditioner
// Conditions the raw street-B vehicle detector into a clean, latched vehicle
// request for signal_vm, and counts accepted arrivals.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   raw_b     : raw detector input (asynchronous, may bounce)
//   Bgo       : street-B green indication from signal_vm
//   b         : registered vehicle request (high only in REQ)
//   arming    : high while a candidate arrival is being debounced
//   car_count : saturating count of accepted arrivals
// Configuration macro:
//   SENSOR_COUNT_EN : when defined, car_count is a saturating counter;
//                     otherwise car_count is tied to 0 and no counter exists.
// -----------------------------------------------------------------------------
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw_b,
    input  logic             Bgo,
    output logic             b,
    output logic             arming,
    output logic [CNT_W-1:0] car_count
);

    localparam logic [DB_W:0] DB_TARGET = (DB_W+1)'(DEBOUNCE_CYCLES);

    logic            w_b_sync;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [DB_W-1:0] r_db_cnt;
    logic [DB_W-1:0] w_db_nxt;
    logic [DB_W:0]   w_db_inc;
    logic            w_accept;
    logic            r_b;
    logic            r_arming;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_b),
        .q   (w_b_sync)
    );

    // Extra bit keeps the compare free of wrap-around at DEBOUNCE_CYCLES=255.
    assign w_db_inc = {1'b0, r_db_cnt} + {{DB_W{1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt = r_state;
        w_db_nxt    = r_db_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_b_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        // A single high sample is already enough: accept now.
                        w_accept    = 1'b1;
                        w_db_nxt    = '0;
                        w_state_nxt = Bgo ? SERVED : REQ;
                    end else begin
                        w_db_nxt    = {{(DB_W-1){1'b0}}, 1'b1};
                        w_state_nxt = ARMING;
                    end
                end
            end
            ARMING: begin
                if (!w_b_sync) begin
                    w_db_nxt    = '0;
                    w_state_nxt = IDLE;
                end else if (w_db_inc >= DB_TARGET) begin
                    w_accept    = 1'b1;
                    w_db_nxt    = '0;
                    // Already green: the vehicle is served without a request.
                    w_state_nxt = Bgo ? SERVED : REQ;
                end else begin
                    w_db_nxt    = w_db_inc[DB_W-1:0];
                end
            end
            REQ: begin
                // Request is latched; only the green indication releases it.
                if (Bgo) begin
                    w_state_nxt = SERVED;
                end
            end
            SERVED: begin
                if (!Bgo) begin
                    if (w_b_sync) begin
                        w_db_nxt    = {{(DB_W-1){1'b0}}, 1'b1};
                        w_state_nxt = ARMING;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_db_nxt    = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_db_cnt <= '0;
            r_b      <= 1'b0;
            r_arming <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_db_cnt <= w_db_nxt;
            r_b      <= (w_state_nxt == REQ);
            r_arming <= (w_state_nxt == ARMING);
        end
    end

    assign b      = r_b;
    assign arming = r_arming;

`ifdef SENSOR_COUNT_EN
    logic [CNT_W-1:0] r_car_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_car_cnt <= '0;
        end else if (w_accept && (r_car_cnt != {CNT_W{1'b1}})) begin
            r_car_cnt <= r_car_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign car_count = r_car_cnt;
`else
    logic w_unused_accept;

    assign w_unused_accept = w_accept;
    assign car_count       = '0;
`endif

endmodule : sensor_conditioner

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized-high cycles needed to accept a vehicle arrival (legal range 1..255).
REQ-002 Parameter CNT_W, default 8: width of the arrival counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 raw_b  input  1  raw street-B vehicle detector; asynchronous to clk, may bounce.
REQ-006 Bgo  input  1  street-B green indication fed back from signal_vm.
REQ-007 b  output  1  registered vehicle request driven to the b input of signal_vm.
REQ-008 arming  output  1  high while a candidate arrival is being debounced.
REQ-009 car_count  output  CNT_W  saturating count of accepted arrivals.

Function
REQ-010 raw_b SHALL pass through a 2-flop synchronizer; b_sync lags raw_b by 2 clk edges.
REQ-011 FSM states SHALL be IDLE, ARMING, REQ, SERVED; b SHALL be 1 only in REQ; arming SHALL be 1 only in ARMING.
REQ-012 IDLE: b_sync=1 -> ARMING with debounce counter loaded to 1; else stay.
REQ-013 ARMING: b_sync=0 -> IDLE and counter cleared; b_sync=1 -> counter increments; the edge on which the counter equals DEBOUNCE_CYCLES is the acceptance edge.
REQ-014 Acceptance with Bgo=0 -> REQ; acceptance with Bgo=1 -> SERVED directly (b never asserts); both cases count one arrival.
REQ-015 With DEBOUNCE_CYCLES=1, IDLE with b_sync=1 SHALL accept on that same edge (IDLE skips ARMING).
REQ-016 REQ: b SHALL remain 1 regardless of b_sync (vehicle latched) until Bgo=1 is sampled, then -> SERVED.
REQ-017 SERVED: Bgo=1 -> stay; Bgo=0 and b_sync=0 -> IDLE; Bgo=0 and b_sync=1 -> ARMING (new vehicle, counter loaded to 1).
REQ-018 b latency: raw_b rising, held stable, SHALL produce b=1 exactly 2+DEBOUNCE_CYCLES edges later.
REQ-019 car_count SHALL increment by 1 on each acceptance edge and hold at 2^CNT_W-1 (no wrap).

Reset
REQ-020 rst=1 on an edge SHALL force state IDLE, synchronizer flops 0, debounce counter 0, b=0, arming=0, car_count=0, overriding all other inputs including mid-REQ/mid-ARMING.
REQ-021 First state change after rst deasserts SHALL depend only on post-reset samples of raw_b (no stale synchronizer data).

Configuration
REQ-022 Macro SENSOR_COUNT_EN defined: car_count counter SHALL be implemented per REQ-019.
REQ-023 Macro SENSOR_COUNT_EN undefined: car_count SHALL be constant 0, no counter flops; all other behaviour identical.

Structure
REQ-024 Shared package sensor_pkg SHALL hold the FSM state encoding (IDLE, ARMING, REQ, SERVED) and default DEBOUNCE_CYCLES/CNT_W constants.
REQ-025 Synchronizer SHALL be a separate sub-module sync_2ff (1-bit, clk, rst, d, q); FSM, debounce counter and car counter stay in sensor_conditioner.

Verification (clk period 100 ns, DEBOUNCE_CYCLES=4, CNT_W=8)
REQ-026 raw_b 0->1 held, Bgo=0 -> arming=1 after edge 3, b=1 at edge 6, car_count=1.
REQ-027 raw_b high 3 cycles then low (bounce), repeated twice -> b stays 0, car_count stays 0, arming pulses.
REQ-028 In REQ, raw_b drops to 0 -> b stays 1; Bgo=1 one cycle later -> b=0 next edge; Bgo=0 with raw_b=0 -> IDLE.
REQ-029 Bgo=1 held while raw_b held high -> acceptance goes to SERVED, b never 1, car_count increments; Bgo=0 with raw_b=1 -> ARMING, second acceptance 4 edges later, car_count=2.
REQ-030 rst=1 for one cycle while in REQ with car_count=5 -> next edge b=0, car_count=0, state IDLE; 300 arrivals -> car_count=255 (and 0 throughout with SENSOR_COUNT_EN undefined).
